sobel_conv_param: RTL and testbench

Parametrised 3×3 Sobel convolution engine for the streaming edge-detection path. It accepts one raster-order pixel per qualified clock and maintains two line buffers plus a 3×3 window. It emits one gradient result per fully populated window, selectable as Gx, Gy, |Gx|+|Gy|, or clamped magnitude. This is the successor of the fixed 5-wide, free-running convolver: it adds configurable geometry, an input qualifier, frame sync and end-of-frame marking.

---
 rtl/sobel_conv_param.sv | 175 +++++++++++++++++
 tb/tb_sobel_conv_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_conv_param.sv
// Streaming 3x3 Sobel convolver: raster pixels in, one gradient result per fully
// populated window out, two registered stages after the pixel is accepted.
`timescale 1ns/1ps
module sobel_conv_param #(
  parameter int PXL_W = 8,
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PXL_W-1:0] pxl_in,
  input  logic             pxl_in_valid,
  input  logic             sof,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] pxl_out,
  output logic             valid,
  output logic             eof
);

  localparam int AW = PXL_W + 4;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [AW-1:0] CLAMP    = {{4{1'b0}}, {PXL_W{1'b1}}};

  typedef enum logic [1:0] {
    MODE_GX    = 2'b00,
    MODE_GY    = 2'b01,
    MODE_SUM   = 2'b10,
    MODE_CLAMP = 2'b11
  } mode_e;

  // Position / frame control
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  mode_e         mode_q, mode_cur;
  logic          frame_start, complete, last_pix;

  // Window (w[r][c], r=0 oldest line, c=2 newest column) and line buffers
  logic [PXL_W-1:0] win_q [3][3];
  logic [PXL_W-1:0] lb0_q [IMG_W];
  logic [PXL_W-1:0] lb1_q [IMG_W];

  // Pipeline stage registers
  logic                 v0_q, e0_q;
  mode_e                m0_q, m1_q;
  logic                 v1_q, e1_q;
  logic signed [AW-1:0] gx_q, gy_q, gx_d, gy_d;
  logic [AW-1:0]        abs_x, abs_y, mag_sum;
  logic [OUT_W-1:0]     out_d, out_q;
  logic                 valid_q, eof_q;

  // A qualified sof pixel is (0,0) no matter where the counters were.
  assign frame_start = pxl_in_valid & sof;
  assign cur_col     = frame_start ? '0 : col_q;
  assign cur_row     = frame_start ? '0 : row_q;
  assign mode_cur    = frame_start ? mode_e'(mode) : mode_q;
  assign complete    = pxl_in_valid && (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
  assign last_pix    = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pxl_in_valid) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= MODE_GX;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (frame_start) mode_q <= mode_e'(mode);
    end
  end

  // NOTE: window and line buffers are reset explicitly; they are small register arrays, not RAM macros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else if (pxl_in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2]    <= lb0_q[cur_col];
      win_q[1][2]    <= lb1_q[cur_col];
      win_q[2][2]    <= pxl_in;
      lb0_q[cur_col] <= lb1_q[cur_col];
      lb1_q[cur_col] <= pxl_in;
    end
  end

  function automatic logic signed [AW-1:0] ext(input logic [PXL_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  always_comb begin
    gx_d = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
         - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
    gy_d = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
         - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));
  end

  // |Gx|+|Gy| tops out at 8*(2^PXL_W-1), so AW unsigned bits always hold it.
  always_comb begin
    abs_x   = gx_q[AW-1] ? -gx_q : gx_q;
    abs_y   = gy_q[AW-1] ? -gy_q : gy_q;
    mag_sum = abs_x + abs_y;
    out_d   = '0;
    case (m1_q)
      MODE_GX:    out_d = OUT_W'(gx_q);
      MODE_GY:    out_d = OUT_W'(gy_q);
      MODE_SUM:   out_d = OUT_W'(mag_sum);
      MODE_CLAMP: out_d = OUT_W'((mag_sum > CLAMP) ? CLAMP : mag_sum);
      default:    out_d = '0;
    endcase
  end

  // The mode travels with each result so a mid-frame sof cannot retag results in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_q    <= 1'b0;
      e0_q    <= 1'b0;
      m0_q    <= MODE_GX;
      v1_q    <= 1'b0;
      e1_q    <= 1'b0;
      m1_q    <= MODE_GX;
      gx_q    <= '0;
      gy_q    <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      v0_q    <= complete;
      e0_q    <= complete & last_pix;
      m0_q    <= mode_cur;
      v1_q    <= v0_q;
      e1_q    <= e0_q;
      m1_q    <= m0_q;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      valid_q <= v1_q;
      eof_q   <= e1_q;
      if (v1_q) out_q <= out_d;
    end
  end

  assign pxl_out = out_q;
  assign valid   = valid_q;
  assign eof     = eof_q;

endmodule

// File: tb/tb_sobel_conv_param.sv
// Bench for sobel_conv_param: a 5x5 and a 3x3 instance, table-driven frames plus
// reset and mid-frame sof sequences, results checked through per-instance scoreboards.
`timescale 1ns/1ps
module tb_sobel_conv_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  pxl5, pxl3;
  logic        v5, v3, sof5, sof3;
  logic [1:0]  mode5, mode3;
  logic [15:0] out5, out3;
  logic        valid5, valid3, eof5, eof3;

  sobel_conv_param dut5 (
    .clk(clk), .reset(reset), .pxl_in(pxl5), .pxl_in_valid(v5), .sof(sof5),
    .mode(mode5), .pxl_out(out5), .valid(valid5), .eof(eof5)
  );

  sobel_conv_param #(.PXL_W(8), .IMG_W(3), .IMG_H(3), .OUT_W(16)) dut3 (
    .clk(clk), .reset(reset), .pxl_in(pxl3), .pxl_in_valid(v3), .sof(sof3),
    .mode(mode3), .pxl_out(out3), .valid(valid3), .eof(eof3)
  );

  typedef struct {
    logic [15:0] val;
    logic        eof;
    int          due;
  } exp_t;

  typedef struct {
    int          dut;
    int          pat;
    logic [1:0]  mode;
    logic        gap;
    logic [15:0] val;
    int          cnt;
  } vec_t;

  exp_t q5[$];
  exp_t q3[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   got5  = 0;
  int   got3  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic score(input int which);
    logic        v, e;
    logic [15:0] d;
    exp_t        f;
    int          n;
    string       nm;
    nm = (which == 0) ? "d5" : "d3";
    if (which == 0) begin
      v = valid5; e = eof5; d = out5; n = q5.size();
      if (n > 0) f = q5[0];
    end else begin
      v = valid3; e = eof3; d = out3; n = q3.size();
      if (n > 0) f = q3[0];
    end
    if (v) begin
      if (n == 0) check({nm, "_unexpected_valid"}, v, 0);
      else begin
        check({nm, "_data"}, d, f.val);
        check({nm, "_eof"}, e, f.eof);
        check({nm, "_latency"}, cyc, f.due);
        if (which == 0) begin void'(q5.pop_front()); got5++; end
        else            begin void'(q3.pop_front()); got3++; end
      end
    end else if (n > 0 && cyc >= f.due) begin
      check({nm, "_missing_valid"}, v, 1);
      if (which == 0) void'(q5.pop_front());
      else            void'(q3.pop_front());
    end
  endtask

  always @(negedge clk) begin
    score(0);
    score(1);
  end

  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      0:       return (r % 2 == 0) ? 8'(c + 1) : 8'(c % 2);
      1:       return (c == 2) ? 8'd255 : 8'd0;
      default: return (c == 0) ? 8'd255 : 8'd0;
    endcase
  endfunction

  task automatic drive_pix(input int which, input logic [7:0] p, input logic s, input logic [1:0] m);
    @(negedge clk);
    if (which == 0) begin
      pxl5 = p; v5 = 1'b1; sof5 = s; mode5 = m; v3 = 1'b0;
    end else begin
      pxl3 = p; v3 = 1'b1; sof3 = s; mode3 = m; v5 = 1'b0;
    end
  endtask

  // Idle cycle: sof high with the qualifier low must be ignored.
  task automatic idle();
    @(negedge clk);
    v5 = 1'b0; v3 = 1'b0; sof5 = 1'b1; sof3 = 1'b1;
    pxl5 = 8'($urandom); pxl3 = 8'($urandom);
    mode5 = 2'($urandom); mode3 = 2'($urandom);
  endtask

  task automatic drive_frame(input int which, input int pat, input logic [1:0] m, input logic gap,
                             input logic use_sof, input int npix, input logic [15:0] val);
    int   w, h, r, c;
    exp_t x;
    w = (which == 0) ? 5 : 3;
    h = w;
    for (int i = 0; i < npix; i++) begin
      r = i / w;
      c = i % w;
      // Mode input only matters on the sof pixel; flip it afterwards.
      drive_pix(which, pix(pat, r, c), use_sof && (i == 0), (i == 0) ? m : ~m);
      if (r >= 2 && c >= 2) begin
        x.val = val;
        x.eof = (r == h - 1) && (c == w - 1);
        x.due = cyc + 3;
        if (which == 0) q5.push_back(x);
        else            q3.push_back(x);
      end
      if (gap) idle();
    end
  endtask

  task automatic finish_seq();
    idle();
    for (int i = 0; i < 40 && (q5.size() + q3.size()) > 0; i++) idle();
    check("drain", q5.size() + q3.size(), 0);
    repeat (4) idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vecs[0] = '{dut: 0, pat: 0, mode: 2'b00, gap: 1'b0, val: 16'd4,    cnt: 9};
    vecs[1] = '{dut: 0, pat: 0, mode: 2'b01, gap: 1'b0, val: 16'd0,    cnt: 9};
    vecs[2] = '{dut: 0, pat: 0, mode: 2'b10, gap: 1'b0, val: 16'd4,    cnt: 9};
    vecs[3] = '{dut: 0, pat: 0, mode: 2'b11, gap: 1'b0, val: 16'd4,    cnt: 9};
    vecs[4] = '{dut: 1, pat: 1, mode: 2'b00, gap: 1'b0, val: 16'd1020, cnt: 1};
    vecs[5] = '{dut: 1, pat: 2, mode: 2'b00, gap: 1'b0, val: 16'hFC04, cnt: 1};
    vecs[6] = '{dut: 1, pat: 1, mode: 2'b10, gap: 1'b0, val: 16'd1020, cnt: 1};
    vecs[7] = '{dut: 1, pat: 1, mode: 2'b11, gap: 1'b0, val: 16'd255,  cnt: 1};
    vecs[8] = '{dut: 0, pat: 0, mode: 2'b00, gap: 1'b1, val: 16'd4,    cnt: 9};

    reset = 1'b0;
    pxl5 = '0; pxl3 = '0; v5 = 1'b0; v3 = 1'b0;
    sof5 = 1'b0; sof3 = 1'b0; mode5 = '0; mode3 = '0;
    repeat (2) @(negedge clk);
    check("reset_out5",   out5,   0);
    check("reset_valid5", valid5, 0);
    check("reset_eof5",   eof5,   0);
    check("reset_out3",   out3,   0);
    check("reset_valid3", valid3, 0);
    check("reset_eof3",   eof3,   0);
    reset = 1'b1;
    repeat (2) idle();

    for (int k = 0; k < 9; k++) begin
      got5 = 0;
      got3 = 0;
      drive_frame(vecs[k].dut, vecs[k].pat, vecs[k].mode, vecs[k].gap, 1'b1,
                  (vecs[k].dut == 0) ? 25 : 9, vecs[k].val);
      finish_seq();
      check($sformatf("vec%0d_count", k), (vecs[k].dut == 0) ? got5 : got3, vecs[k].cnt);
    end

    // Reset pulse right after pixel (2,2): its result must never appear.
    got5 = 0;
    drive_frame(0, 0, 2'b00, 1'b0, 1'b1, 13, 16'd4);
    @(negedge clk);
    reset = 1'b0;
    v5 = 1'b0;
    q5.delete();
    #1;
    check("midreset_valid", valid5, 0);
    check("midreset_out",   out5,   0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) idle();
    check("midreset_count", got5, 0);

    // Fresh frame without sof: counters restart at (0,0), latched mode back to Gx.
    got5 = 0;
    drive_frame(0, 0, 2'b01, 1'b0, 1'b0, 25, 16'd4);
    finish_seq();
    check("after_reset_count", got5, 9);

    // sof at position (3,1) with a switch to Gy; row-2 results still in flight stay Gx.
    got5 = 0;
    drive_frame(0, 0, 2'b00, 1'b0, 1'b1, 16, 16'd4);
    drive_frame(0, 0, 2'b01, 1'b0, 1'b1, 25, 16'd0);
    finish_seq();
    check("midsof_count", got5, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
